uart_sync_fifo: RTL and testbench

UART_SYNC_FIFO -- requirements
Module: uart_sync_fifo

---
 rtl/uart_fifo_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 23 ++
 rtl/uart_sync_fifo.sv | 103 ++++++++++
 tb/tb_uart_sync_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART receive FIFO.
package uart_fifo_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_FIFO_WIDTH = 4;

    // Occupancy needs one bit more than the pointers to represent "full".
    typedef logic [DEF_FIFO_WIDTH:0] fifo_cnt_t;

    typedef struct packed {
        logic ovf;
        logic udf;
    } sticky_t;

    function automatic int fifo_depth(input int ptr_w);
        return 1 << ptr_w;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART receive FIFO with sticky error flags, flush and BIST freeze.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_BITS-1:0]  Rx_Data,
    input  logic                  Push,
    input  logic                  Pop,
    input  logic                  Clr,
    input  logic                  BIST_Mode,
    input  logic [FIFO_WIDTH:0]   Thresh,
    output logic [DATA_BITS-1:0]  Data_Out,
    output logic                  Data_Valid,
    output logic                  FIFO_Empty,
    output logic                  FIFO_Full,
    output logic                  FIFO_Almost_Full,
    output logic                  FIFO_Overflow,
    output logic                  FIFO_Underflow,
    output logic [FIFO_WIDTH:0]   Count
);

    localparam int                  DEPTH   = fifo_depth(FIFO_WIDTH);
    localparam logic [FIFO_WIDTH:0] DEPTH_C = DEPTH[FIFO_WIDTH:0];
    localparam logic [FIFO_WIDTH:0] CNT_ONE = (FIFO_WIDTH+1)'(1);

    logic [FIFO_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [FIFO_WIDTH:0]   count;
    logic [DATA_BITS-1:0]  head;
    sticky_t               sticky;
    logic                  active, push_ok, pop_ok;

    // Pop is judged on the pre-edge count, so a same-cycle push never rescues an empty pop.
    assign active  = !BIST_Mode && !Clr;
    assign pop_ok  = active && Pop && (count != '0);
    assign push_ok = active && Push && ((count != DEPTH_C) || pop_ok);

    uart_fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .ADDR_W    (FIFO_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (Rx_Data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sticky <= '0;
        end else if (Clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sticky <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (active && Push && !push_ok) sticky.ovf <= 1'b1;
            if (active && Pop  && !pop_ok)  sticky.udf <= 1'b1;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    assign Data_Out   = FIFO_Empty ? '0 : head;
    assign Data_Valid = !FIFO_Empty;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
        end else if (Clr) begin
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
        end else begin
            Data_Valid <= pop_ok;
            if (pop_ok) Data_Out <= head;
        end
    end
`endif

    assign Count            = count;
    assign FIFO_Empty       = (count == '0);
    assign FIFO_Full        = (count == DEPTH_C);
    assign FIFO_Almost_Full = (count >= Thresh);
    assign FIFO_Overflow    = sticky.ovf;
    assign FIFO_Underflow   = sticky.udf;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed self-checking bench for uart_sync_fifo (DATA_BITS=8, DEPTH=16).
module tb_uart_sync_fifo;

    localparam int DW = 8;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Push = 1'b0, Pop = 1'b0, Clr = 1'b0, BIST_Mode = 1'b0;
    logic [DW-1:0] Rx_Data = '0;
    logic [FW:0]   Thresh = 5'd4;
    logic [DW-1:0] Data_Out;
    logic          Data_Valid, FIFO_Empty, FIFO_Full, FIFO_Almost_Full;
    logic          FIFO_Overflow, FIFO_Underflow;
    logic [FW:0]   Count;

    int n_vec = 0;
    int n_err = 0;

    uart_sync_fifo #(.DATA_BITS(DW), .FIFO_WIDTH(FW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .Rx_Data          (Rx_Data),
        .Push             (Push),
        .Pop              (Pop),
        .Clr              (Clr),
        .BIST_Mode        (BIST_Mode),
        .Thresh           (Thresh),
        .Data_Out         (Data_Out),
        .Data_Valid       (Data_Valid),
        .FIFO_Empty       (FIFO_Empty),
        .FIFO_Full        (FIFO_Full),
        .FIFO_Almost_Full (FIFO_Almost_Full),
        .FIFO_Overflow    (FIFO_Overflow),
        .FIFO_Underflow   (FIFO_Underflow),
        .Count            (Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        Push = 1'b1;
        Rx_Data = d;
        tick();
        Push = 1'b0;
    endtask

    task automatic pop(input logic [DW-1:0] exp);
`ifdef UART_FIFO_FWFT_EN
        chk("fwft_head", 32'(Data_Out), 32'(exp));
        chk("fwft_valid", 32'(Data_Valid), 1);
        Pop = 1'b1;
        tick();
        Pop = 1'b0;
`else
        Pop = 1'b1;
        tick();
        Pop = 1'b0;
        chk("pop_data", 32'(Data_Out), 32'(exp));
        chk("pop_valid", 32'(Data_Valid), 1);
`endif
    endtask

    initial begin
        // Reset state, checked before any clock edge
        #2;
        chk("rst_count", 32'(Count), 0);
        chk("rst_empty", 32'(FIFO_Empty), 1);
        chk("rst_full", 32'(FIFO_Full), 0);
        chk("rst_afull_t4", 32'(FIFO_Almost_Full), 0);
        chk("rst_dout", 32'(Data_Out), 0);
        chk("rst_valid", 32'(Data_Valid), 0);
        chk("rst_ovf", 32'(FIFO_Overflow), 0);
        chk("rst_udf", 32'(FIFO_Underflow), 0);
        Thresh = 5'd0;
        #1;
        chk("rst_afull_t0", 32'(FIFO_Almost_Full), 1);
        Thresh = 5'd4;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic in-order traffic
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("cnt3", 32'(Count), 3);
        chk("not_empty", 32'(FIFO_Empty), 0);
        pop(8'h11);
        chk("cnt2", 32'(Count), 2);
`ifndef UART_FIFO_FWFT_EN
        tick();
        chk("valid_pulse", 32'(Data_Valid), 0);
        chk("dout_hold", 32'(Data_Out), 32'h11);
`endif
        pop(8'h22);
        pop(8'h33);
        chk("cnt0", 32'(Count), 0);
        chk("empty_again", 32'(FIFO_Empty), 1);

        // Push+pop into empty: pop rejected, push taken
        Rx_Data = 8'h5A;
        Push = 1'b1;
        Pop = 1'b1;
        tick();
        Push = 1'b0;
        Pop = 1'b0;
        chk("udf_set", 32'(FIFO_Underflow), 1);
        chk("udf_cnt1", 32'(Count), 1);
        chk("udf_no_ovf", 32'(FIFO_Overflow), 0);
`ifndef UART_FIFO_FWFT_EN
        chk("udf_no_valid", 32'(Data_Valid), 0);
`endif
        tick();
        chk("udf_sticky", 32'(FIFO_Underflow), 1);
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        chk("clr_cnt", 32'(Count), 0);
        chk("clr_udf", 32'(FIFO_Underflow), 0);
        chk("clr_dout", 32'(Data_Out), 0);
        chk("clr_empty", 32'(FIFO_Empty), 1);

        // Fill to DEPTH; almost-full rises on the 4th push
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h80 + i));
            if (i == 2) chk("afull_lo", 32'(FIFO_Almost_Full), 0);
            if (i == 3) chk("afull_hi", 32'(FIFO_Almost_Full), 1);
        end
        chk("full_cnt", 32'(Count), 16);
        chk("full_flag", 32'(FIFO_Full), 1);
        chk("full_no_ovf", 32'(FIFO_Overflow), 0);
        Thresh = 5'd17;
        #1;
        chk("afull_t17", 32'(FIFO_Almost_Full), 0);
        Thresh = 5'd16;
        #1;
        chk("afull_t16", 32'(FIFO_Almost_Full), 1);
        Thresh = 5'd4;
        push(8'hEE);
        chk("ovf_set", 32'(FIFO_Overflow), 1);
        chk("ovf_cnt", 32'(Count), 16);

        // Full with simultaneous push+pop: both taken, pointers wrap
`ifdef UART_FIFO_FWFT_EN
        chk("fwft_full_head", 32'(Data_Out), 32'h80);
`endif
        Rx_Data = 8'hAA;
        Push = 1'b1;
        Pop = 1'b1;
        tick();
        Push = 1'b0;
        Pop = 1'b0;
`ifndef UART_FIFO_FWFT_EN
        chk("pp_dout", 32'(Data_Out), 32'h80);
`endif
        chk("pp_cnt", 32'(Count), 16);
        chk("pp_full", 32'(FIFO_Full), 1);
        for (int i = 1; i < 16; i++)
            pop(8'(8'h80 + i));
        pop(8'hAA);
        chk("drain_cnt", 32'(Count), 0);
        chk("drain_empty", 32'(FIFO_Empty), 1);
        chk("ovf_sticky", 32'(FIFO_Overflow), 1);

        // BIST freeze, then Clr while frozen
        push(8'h01);
        push(8'h02);
        BIST_Mode = 1'b1;
        Rx_Data = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            Push = i[0];
            Pop = !i[0] || (i == 4);
            tick();
        end
        Push = 1'b0;
        Pop = 1'b0;
        chk("bist_cnt", 32'(Count), 2);
        chk("bist_ovf", 32'(FIFO_Overflow), 1);
        chk("bist_udf", 32'(FIFO_Underflow), 0);
`ifndef UART_FIFO_FWFT_EN
        chk("bist_valid", 32'(Data_Valid), 0);
`endif
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        BIST_Mode = 1'b0;
        chk("bclr_cnt", 32'(Count), 0);
        chk("bclr_ovf", 32'(FIFO_Overflow), 0);
        chk("bclr_udf", 32'(FIFO_Underflow), 0);
        chk("bclr_empty", 32'(FIFO_Empty), 1);

        // Asynchronous reset in the middle of a burst
        push(8'h31);
        push(8'h32);
        push(8'h33);
        pop(8'h31);
        Push = 1'b1;
        Rx_Data = 8'h34;
        tick();
        chk("burst_cnt", 32'(Count), 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(Count), 0);
        chk("arst_empty", 32'(FIFO_Empty), 1);
        chk("arst_full", 32'(FIFO_Full), 0);
        chk("arst_afull", 32'(FIFO_Almost_Full), 0);
        chk("arst_dout", 32'(Data_Out), 0);
        chk("arst_valid", 32'(Data_Valid), 0);
        Push = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        push(8'h77);
        pop(8'h77);
        chk("post_rst_cnt", 32'(Count), 0);
        chk("post_rst_empty", 32'(FIFO_Empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
